// File: rtl/mpe_dispatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mpe_dispatch : hands one uop to the matrix PE, then streams NRAM/WRAM reads
// Rev 1.0
// ----------------------------------------------------------------------------
module mpe_dispatch #(
   parameter int AW = 16,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_uop,
   input  logic [AW-1:0] cmd_n_base,
   input  logic [AW-1:0] cmd_w_base,
   input  logic [LW-1:0] cmd_len,
   output logic [7:0]    ib_ctl_uop,
   output logic          ib_ctl_uop_valid,
   input  logic          ib_ctl_uop_ready,
   output logic [AW-1:0] nram_raddr,
   output logic          nram_rd_valid,
   input  logic          nram_rd_ready,
   output logic [AW-1:0] wram_raddr,
   output logic          wram_rd_valid,
   input  logic          wram_rd_ready,
   input  logic          pe_vld_o,
   output logic          busy,
   output logic          done,
   output logic          err_len0,
   output logic [15:0]   cmd_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_FETCH = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_uop;
   logic [AW-1:0] r_n_addr;
   logic [AW-1:0] r_w_addr;
   logic [LW-1:0] r_n_rem;
   logic [LW-1:0] r_w_rem;
   logic          r_pe_seen;
   logic          r_err;
   logic [15:0]   r_cnt;

   logic          w_cmd_hs;
   logic          w_n_hs;
   logic          w_w_hs;
   logic          w_n_empty_nxt;
   logic          w_w_empty_nxt;
   logic          w_fetch_end;

   // Valids depend only on registered state, so no ready->valid comb path.
   assign cmd_ready        = (r_state == S_IDLE);
   assign busy             = (r_state != S_IDLE);
   assign ib_ctl_uop       = r_uop;
   assign ib_ctl_uop_valid = (r_state == S_ISSUE);
   assign nram_raddr       = r_n_addr;
   assign wram_raddr       = r_w_addr;
   assign nram_rd_valid    = (r_state == S_FETCH) && (r_n_rem != '0);
   assign wram_rd_valid    = (r_state == S_FETCH) && (r_w_rem != '0);
   assign err_len0         = r_err;
   assign cmd_cnt          = r_cnt;

   assign w_cmd_hs      = cmd_valid && cmd_ready;
   assign w_n_hs        = nram_rd_valid && nram_rd_ready;
   assign w_w_hs        = wram_rd_valid && wram_rd_ready;
   assign w_n_empty_nxt = (r_n_rem == '0) || (w_n_hs && (r_n_rem == LW'(1)));
   assign w_w_empty_nxt = (r_w_rem == '0) || (w_w_hs && (r_w_rem == LW'(1)));
   assign w_fetch_end   = (r_state == S_FETCH) && w_n_empty_nxt && w_w_empty_nxt;

   always_comb begin
      w_state_nxt = r_state;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_hs && (cmd_len != '0)) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ib_ctl_uop_ready) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            // A result that arrived early finishes the command without visiting WAIT.
            if (w_fetch_end) begin
               if (r_pe_seen || pe_vld_o) begin
                  w_state_nxt = S_IDLE;
                  done        = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (pe_vld_o) begin
               w_state_nxt = S_IDLE;
               done        = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_uop     <= '0;
         r_n_addr  <= '0;
         r_w_addr  <= '0;
         r_n_rem   <= '0;
         r_w_rem   <= '0;
         r_pe_seen <= 1'b0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_cmd_hs && (cmd_len == '0);
         if (w_cmd_hs) begin
            r_uop     <= cmd_uop;
            r_n_addr  <= cmd_n_base;
            r_w_addr  <= cmd_w_base;
            r_n_rem   <= cmd_len;
            r_w_rem   <= cmd_len;
            r_pe_seen <= 1'b0;
         end
         if (w_n_hs) begin
            r_n_addr <= r_n_addr + AW'(1);
            r_n_rem  <= r_n_rem - LW'(1);
         end
         if (w_w_hs) begin
            r_w_addr <= r_w_addr + AW'(1);
            r_w_rem  <= r_w_rem - LW'(1);
         end
         if ((r_state == S_FETCH) && pe_vld_o) begin
            r_pe_seen <= 1'b1;
         end
         if (done) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
